// File: rtl/icetap_cmd_status_pkg.sv
// Shared constants for the icetap command/status block: opcode values,
// status chain bit positions, and the NOP test used on update.
package icetap_cmd_status_pkg;

  localparam logic [3:0] ICETAP_OP_NOP      = 4'd0;
  localparam logic [3:0] ICETAP_OP_ARM      = 4'd1;
  localparam logic [3:0] ICETAP_OP_ABORT    = 4'd2;
  localparam logic [3:0] ICETAP_OP_CLEAR    = 4'd3;
  localparam logic [3:0] ICETAP_OP_READ_PTR = 4'd4;

  localparam int unsigned ICETAP_STAT_BUSY_BIT = 0;
  localparam int unsigned ICETAP_STAT_OVR_BIT  = 1;

  function automatic logic icetap_is_nop(input logic [3:0] opcode);
    return (opcode == ICETAP_OP_NOP);
  endfunction

endpackage

// File: rtl/icetap_cmd_status_sync2.sv
// Two-flop synchronizer, parameterized width, async active-low reset.
// Used for the ack toggle and the quasi-static core status bus.
module icetap_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/icetap_cmd_status.sv
// JTAG-side command issue (toggle req/ack) and status snapshot chain in tck.
// Define ICETAP_CMD_ECHO_EN to append the last accepted command to the status chain.
module icetap_cmd_status
  import icetap_cmd_status_pkg::*;
#(
  parameter int CMD_WIDTH    = 8,
  parameter int STATUS_WIDTH = 16
) (
  input  logic                    tck,
  input  logic                    trst_n,
  input  logic                    cmd_shift_ena,
  input  logic                    cmd_shift_update,
  input  logic                    cmd_shift_data,
  input  logic                    status_shift_update,
  input  logic                    status_shift_ena,
  output logic                    status_shift_data,
  output logic [CMD_WIDTH-1:0]    cmd_valid_cmd,
  output logic                    cmd_req_tgl,
  input  logic                    cmd_ack_tgl,
  input  logic [STATUS_WIDTH-3:0] core_status,
  output logic                    cmd_busy
);

`ifdef ICETAP_CMD_ECHO_EN
  localparam int SR_W = STATUS_WIDTH + CMD_WIDTH;
`else
  localparam int SR_W = STATUS_WIDTH;
`endif

  logic [CMD_WIDTH-1:0]    cmd_sr_q, cmd_sr_d;
  logic [CMD_WIDTH-1:0]    cmd_valid_q, cmd_valid_d;
  logic                    req_q, req_d;
  logic                    busy_q;
  logic                    ovr_q, ovr_d;
  logic                    ovr_set;
  logic [SR_W-1:0]         status_sr_q, status_sr_d;
  logic [SR_W-1:0]         snapshot;
  logic                    ack_s;
  logic [STATUS_WIDTH-3:0] status_s;

  icetap_sync2 #(.W(1)) u_ack_sync (
    .clk_i  (tck),
    .rst_ni (trst_n),
    .d_i    (cmd_ack_tgl),
    .q_o    (ack_s)
  );

  icetap_sync2 #(.W(STATUS_WIDTH-2)) u_status_sync (
    .clk_i  (tck),
    .rst_ni (trst_n),
    .d_i    (core_status),
    .q_o    (status_s)
  );

`ifdef ICETAP_CMD_ECHO_EN
  assign snapshot = {cmd_valid_q, status_s, ovr_q, busy_q};
`else
  assign snapshot = {status_s, ovr_q, busy_q};
`endif

  // Command chain: shift, or on update either issue, drop (overrun) or ignore a NOP.
  always_comb begin
    cmd_sr_d    = cmd_sr_q;
    cmd_valid_d = cmd_valid_q;
    req_d       = req_q;
    ovr_set     = 1'b0;
    if (cmd_shift_update) begin
      if (icetap_is_nop(cmd_sr_q[3:0])) begin
        ovr_set = 1'b0;
      end else if (!busy_q) begin
        cmd_valid_d = cmd_sr_q;
        req_d       = ~req_q;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (cmd_shift_ena) begin
      cmd_sr_d = {cmd_shift_data, cmd_sr_q[CMD_WIDTH-1:1]};
    end else begin
      cmd_sr_d = cmd_sr_q;
    end
  end

  // Status chain: capture wins over shift; a coincident overrun set survives the read-clear.
  always_comb begin
    status_sr_d = status_sr_q;
    ovr_d       = ovr_q;
    if (status_shift_update) begin
      status_sr_d = snapshot;
      ovr_d       = 1'b0;
    end else if (status_shift_ena) begin
      status_sr_d = {1'b0, status_sr_q[SR_W-1:1]};
    end else begin
      status_sr_d = status_sr_q;
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_d;
    end
  end

  // State registers; busy compares the issued toggle with the synchronized ack.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      cmd_sr_q    <= '0;
      cmd_valid_q <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      status_sr_q <= '0;
    end else begin
      cmd_sr_q    <= cmd_sr_d;
      cmd_valid_q <= cmd_valid_d;
      req_q       <= req_d;
      busy_q      <= (req_q != ack_s);
      ovr_q       <= ovr_d;
      status_sr_q <= status_sr_d;
    end
  end

  assign cmd_valid_cmd     = cmd_valid_q;
  assign cmd_req_tgl       = req_q;
  assign cmd_busy          = busy_q;
  assign status_shift_data = status_sr_q[0];

endmodule

// File: tb/tb_icetap_cmd_status.sv
// Randomized self-checking bench for icetap_cmd_status against a transaction-level model.
module tb_icetap_cmd_status;

  localparam int CW = 8;
  localparam int SW = 16;
`ifdef ICETAP_CMD_ECHO_EN
  localparam int SRW = SW + CW;
`else
  localparam int SRW = SW;
`endif

  logic          tck = 1'b0;
  logic          trst_n;
  logic          cmd_shift_ena, cmd_shift_update, cmd_shift_data;
  logic          status_shift_update, status_shift_ena, status_shift_data;
  logic [CW-1:0] cmd_valid_cmd;
  logic          cmd_req_tgl, cmd_ack_tgl, cmd_busy;
  logic [SW-3:0] core_status;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  bit            m_bits[$];
  logic [CW-1:0] m_valid;
  logic          m_req;
  logic          m_ovr;
  logic [SW-3:0] m_status;

  icetap_cmd_status #(.CMD_WIDTH(CW), .STATUS_WIDTH(SW)) dut (
    .tck                 (tck),
    .trst_n              (trst_n),
    .cmd_shift_ena       (cmd_shift_ena),
    .cmd_shift_update    (cmd_shift_update),
    .cmd_shift_data      (cmd_shift_data),
    .status_shift_update (status_shift_update),
    .status_shift_ena    (status_shift_ena),
    .status_shift_data   (status_shift_data),
    .cmd_valid_cmd       (cmd_valid_cmd),
    .cmd_req_tgl         (cmd_req_tgl),
    .cmd_ack_tgl         (cmd_ack_tgl),
    .core_status         (core_status),
    .cmd_busy            (cmd_busy)
  );

  always #5 tck = ~tck;

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge tck);
  endtask

  // The assembled word is the last CW bits shifted, most recent at the MSB.
  function automatic logic [CW-1:0] model_word();
    logic [CW-1:0] w;
    int base;
    base = m_bits.size() - CW;
    for (int i = 0; i < CW; i++) w[i] = m_bits[base + i];
    return w;
  endfunction

  function automatic logic model_busy();
    return m_req != cmd_ack_tgl;
  endfunction

  task automatic model_clear();
    m_bits.delete();
    for (int i = 0; i < CW; i++) m_bits.push_back(1'b0);
    m_valid = '0;
    m_req   = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_update();
    logic [CW-1:0] w;
    w = model_word();
    if (w[3:0] == 4'd0) begin
    end else if (model_busy()) begin
      m_ovr = 1'b1;
    end else begin
      m_valid = w;
      m_req   = ~m_req;
    end
  endtask

  task automatic shift_word(input logic [CW-1:0] w, input int junk);
    for (int i = 0; i < junk + CW; i++) begin
      cmd_shift_ena  = 1'b1;
      cmd_shift_data = (i < junk) ? 1'($urandom_range(0, 1)) : w[i - junk];
      m_bits.push_back(cmd_shift_data);
      cyc();
    end
    cmd_shift_ena = 1'b0;
  endtask

  // Shift, update, check the update-edge outputs and the settled busy state.
  task automatic issue(input string tag, input logic [CW-1:0] w, input int junk);
    shift_word(w, junk);
    cmd_shift_update = 1'b1;
    model_update();
    cyc();
    cmd_shift_update = 1'b0;
    n_checks++;
    if (cmd_valid_cmd !== m_valid || cmd_req_tgl !== m_req) begin
      n_errors++;
      $display("FAIL %s update: valid=%h req=%b expected valid=%h req=%b", tag, cmd_valid_cmd, cmd_req_tgl, m_valid, m_req);
    end
    cyc(4);
    n_checks++;
    if (cmd_busy !== model_busy()) begin
      n_errors++;
      $display("FAIL %s busy: got %b expected %b", tag, cmd_busy, model_busy());
    end
  endtask

  task automatic toggle_ack_settle();
    cmd_ack_tgl = ~cmd_ack_tgl;
    cyc(4);
  endtask

  // Capture (with shift also asserted: capture must win) then shift out the chain plus extra bits.
  task automatic read_status(input string tag);
    logic [SRW-1:0] exp, got;
    logic           extra;
    exp = '0;
    exp[0] = model_busy();
    exp[1] = m_ovr;
    exp[SW-1:2] = m_status;
`ifdef ICETAP_CMD_ECHO_EN
    exp[SRW-1:SW] = m_valid;
`endif
    status_shift_update = 1'b1;
    status_shift_ena    = 1'b1;
    cyc();
    status_shift_update = 1'b0;
    m_ovr = 1'b0;
    got[0] = status_shift_data;
    for (int i = 1; i < SRW; i++) begin
      cyc();
      got[i] = status_shift_data;
    end
    extra = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      extra = extra | status_shift_data;
    end
    status_shift_ena = 1'b0;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s stream: got %h expected %h", tag, got, exp);
    end
    n_checks++;
    if (extra !== 1'b0) begin
      n_errors++;
      $display("FAIL %s overshift: got %b expected 0", tag, extra);
    end
  endtask

  task automatic set_status(input logic [SW-3:0] v);
    core_status = v;
    m_status    = v;
    cyc(3);
  endtask

  task automatic test_reset();
    trst_n = 1'b0;
    cmd_shift_ena = 1'b0; cmd_shift_update = 1'b0; cmd_shift_data = 1'b0;
    status_shift_update = 1'b0; status_shift_ena = 1'b0;
    cmd_ack_tgl = 1'b0; core_status = '0; m_status = '0;
    model_clear();
    cyc(3);
    n_checks++;
    if ({cmd_valid_cmd, cmd_req_tgl, cmd_busy, status_shift_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%h req=%b busy=%b sdata=%b expected all 0", cmd_valid_cmd, cmd_req_tgl, cmd_busy, status_shift_data);
    end
    trst_n = 1'b1;
    cyc(2);
    read_status("reset_read");
  endtask

  task automatic test_cmd_issue();
    shift_word(8'h31, 0);
    cmd_shift_update = 1'b1;
    model_update();
    cyc();
    cmd_shift_update = 1'b0;
    n_checks++;
    if (cmd_valid_cmd !== 8'h31 || cmd_req_tgl !== 1'b1 || cmd_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL issue_edge: valid=%h req=%b busy=%b expected 31 1 0", cmd_valid_cmd, cmd_req_tgl, cmd_busy);
    end
    cyc();
    n_checks++;
    if (cmd_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL issue_busy_rise: got %b expected 1", cmd_busy);
    end
    cyc(2);
`ifdef ICETAP_CMD_ECHO_EN
    read_status("echo_read");
`endif
    cmd_ack_tgl = ~cmd_ack_tgl;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_checks++;
      if (cmd_busy !== (i < 3)) begin
        n_errors++;
        $display("FAIL ack_latency cycle %0d: busy=%b expected %b", i, cmd_busy, (i < 3));
      end
    end
    cyc();
  endtask

  task automatic test_nop();
    issue("nop", 8'h50, 0);
    n_checks++;
    if (cmd_valid_cmd !== 8'h31 || cmd_req_tgl !== 1'b1) begin
      n_errors++;
      $display("FAIL nop_unchanged: valid=%h req=%b expected 31 1", cmd_valid_cmd, cmd_req_tgl);
    end
    read_status("nop_read");
  endtask

  task automatic test_overrun();
    issue("ovr_first", 8'h01, 0);
    issue("ovr_second", 8'h02, 0);
    n_checks++;
    if (cmd_valid_cmd !== 8'h01) begin
      n_errors++;
      $display("FAIL overrun_hold: valid=%h expected 01", cmd_valid_cmd);
    end
    read_status("ovr_read1");
    read_status("ovr_read2");
    toggle_ack_settle();
  endtask

  task automatic test_status_path();
    set_status(14'h1ABC);
    read_status("status_1abc");
    set_status(14'h2543);
    read_status("status_2543");
  endtask

  // Update with shift asserted uses the pre-shift word and discards the shift.
  task automatic test_collision();
    shift_word(8'h05, 2);
    cmd_shift_ena = 1'b1; cmd_shift_data = 1'b1; cmd_shift_update = 1'b1;
    model_update();
    cyc();
    cmd_shift_ena = 1'b0; cmd_shift_update = 1'b0;
    n_checks++;
    if (cmd_valid_cmd !== 8'h05 || cmd_req_tgl !== m_req) begin
      n_errors++;
      $display("FAIL collision_update: valid=%h req=%b expected 05 %b", cmd_valid_cmd, cmd_req_tgl, m_req);
    end
    cyc(3);
    toggle_ack_settle();
    cmd_shift_update = 1'b1;
    model_update();
    cyc();
    cmd_shift_update = 1'b0;
    n_checks++;
    if (cmd_valid_cmd !== 8'h05 || cmd_req_tgl !== m_req) begin
      n_errors++;
      $display("FAIL collision_discard: valid=%h req=%b expected 05 %b", cmd_valid_cmd, cmd_req_tgl, m_req);
    end
    cyc(3);
    toggle_ack_settle();
  endtask

  task automatic test_random();
    logic [CW-1:0] w;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          w = CW'($urandom);
          if ($urandom_range(0, 3) == 0) w[3:0] = 4'd0;
          issue("rand_issue", w, $urandom_range(0, 4));
        end
        2: begin
          if (model_busy()) toggle_ack_settle();
          n_checks++;
          if (cmd_busy !== model_busy()) begin
            n_errors++;
            $display("FAIL rand_ack busy: got %b expected %b", cmd_busy, model_busy());
          end
        end
        default: begin
          set_status((SW-2)'($urandom));
          read_status("rand_status");
        end
      endcase
    end
    if (model_busy()) toggle_ack_settle();
  endtask

  task automatic test_proto_error();
    toggle_ack_settle();
    n_checks++;
    if (cmd_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL stray_ack busy: got %b expected 1", cmd_busy);
    end
    toggle_ack_settle();
    n_checks++;
    if (cmd_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_ack clear: got %b expected 0", cmd_busy);
    end
  endtask

  task automatic test_reset_mid();
    issue("mid_issue", 8'h13, 0);
    trst_n = 1'b0;
    cmd_ack_tgl = 1'b0;
    model_clear();
    cyc(2);
    n_checks++;
    if (cmd_req_tgl !== 1'b0 || cmd_valid_cmd !== '0 || cmd_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid: req=%b valid=%h busy=%b expected 0 00 0", cmd_req_tgl, cmd_valid_cmd, cmd_busy);
    end
    trst_n = 1'b1;
    cyc(4);
    read_status("reset_mid_read");
  endtask

  initial begin
    test_reset();
    test_cmd_issue();
    test_nop();
    test_overrun();
    test_status_path();
    test_collision();
    test_random();
    test_proto_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
